// File: rtl/pipeline_core_if.sv
// Board-side signals of pipeline_core: step/override buttons in,
// observation taps out.
interface pipeline_core_if;
  logic        btn;
  logic        btnSelect;
  logic        btnWRselect;
  logic        btnMuxEx;
  logic [3:0]  jmpAddr;
  logic        zeroAlu;
  logic [31:0] outMuxWb;

  modport master (
    output btn, btnSelect, btnWRselect, btnMuxEx, jmpAddr,
    input  zeroAlu, outMuxWb
  );

  modport slave (
    input  btn, btnSelect, btnWRselect, btnMuxEx, jmpAddr,
    output zeroAlu, outMuxWb
  );
endinterface

// File: rtl/pipeline_core.sv
// Button-stepped 5-stage teaching pipeline (IF/ID/EX/MEM/WB).
// Define PIPELINE_BTN_SYNC_EN for a synchronised one-step-per-press btn.
module pipeline_core (
  input logic            clk,
  input logic            rst_n,
  pipeline_core_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } aluOp_t;

  typedef struct packed {
    aluOp_t      aluOp;
    logic        useImm;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
  } idEx_t;

  typedef struct packed {
    logic [31:0] aluRes;
    logic [31:0] rtVal;
    logic        zero;
    logic [4:0]  wr;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
  } exMem_t;

  typedef struct packed {
    logic [31:0] wbData;
    logic [4:0]  wr;
    logic        regWrite;
  } memWb_t;

  logic        step;
  logic [3:0]  pc;
  logic [31:0] romData;
  logic [31:0] ifId;
  idEx_t       idEx;
  idEx_t       idNext;
  exMem_t      exMem;
  exMem_t      exNext;
  memWb_t      memWb;
  memWb_t      wbNext;
  logic [31:0] rf [32];
  logic [31:0] dmem [16];

`ifdef PIPELINE_BTN_SYNC_EN
  logic [1:0] btnSync;
  logic       btnPrev;

  // two-flop synchroniser plus rising-edge detector on btn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnSync <= '0;
      btnPrev <= 1'b0;
    end else begin
      btnSync <= {btnSync[0], bus.btn};
      btnPrev <= btnSync[1];
    end
  end

  assign step = btnSync[1] & ~btnPrev;
`else
  assign step = bus.btn;
`endif

  // fixed instruction ROM
  always_comb begin
    unique case (pc)
      4'd0:    romData = 32'h0022_1820;
      4'd1:    romData = 32'h0042_2022;
      4'd2:    romData = 32'h0022_2825;
      4'd3:    romData = 32'h00E2_3024;
      4'd4:    romData = 32'h8C08_0004;
      4'd5:    romData = 32'hAC01_0004;
      default: romData = 32'h0000_0000;
    endcase
  end

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic        wbWe;
  logic        isR;
  logic        isLw;
  logic        isSw;
  logic [31:0] rsRead;
  logic [31:0] rtRead;

  assign op    = ifId[31:26];
  assign rs    = ifId[25:21];
  assign rt    = ifId[20:16];
  assign rd    = ifId[15:11];
  assign funct = ifId[5:0];
  assign isR   = (op == 6'h00);
  assign isLw  = (op == 6'h23);
  assign isSw  = (op == 6'h2B);

  // write-through: the value retiring this step bypasses the array
  assign wbWe = memWb.regWrite && (memWb.wr != 5'd0);
  assign rsRead = (rs == 5'd0) ? 32'd0 :
    (wbWe && memWb.wr == rs) ? memWb.wbData : rf[rs];
  assign rtRead = (rt == 5'd0) ? 32'd0 :
    (wbWe && memWb.wr == rt) ? memWb.wbData : rf[rt];

  // ID: decode controls and capture operands
  always_comb begin
    idNext = '0;
    idNext.rsVal  = rsRead;
    idNext.rtVal  = rtRead;
    idNext.imm    = {{16{ifId[15]}}, ifId[15:0]};
    idNext.useImm = !isR;
    idNext.wr     = (!isR || bus.btnWRselect) ? rt : rd;
    idNext.aluOp  = ALU_ADD;
    unique case (1'b1)
      isR: begin
        idNext.regWrite = 1'b1;
        unique case (funct)
          6'h22:   idNext.aluOp = ALU_SUB;
          6'h24:   idNext.aluOp = ALU_AND;
          6'h25:   idNext.aluOp = ALU_OR;
          6'h2A:   idNext.aluOp = ALU_SLT;
          default: idNext.aluOp = ALU_ADD;
        endcase
      end
      isLw: begin
        idNext.regWrite = 1'b1;
        idNext.memRead  = 1'b1;
      end
      isSw:    idNext.memWrite = 1'b1;
      default: idNext.regWrite = 1'b0;
    endcase
  end

  logic [31:0] aluB;
  logic [31:0] aluRes;

  assign aluB = (idEx.useImm || bus.btnMuxEx) ? idEx.imm : idEx.rtVal;

  // EX: ALU
  always_comb begin
    aluRes = idEx.rsVal + aluB;
    unique case (idEx.aluOp)
      ALU_SUB: aluRes = idEx.rsVal - aluB;
      ALU_AND: aluRes = idEx.rsVal & aluB;
      ALU_OR:  aluRes = idEx.rsVal | aluB;
      ALU_SLT: aluRes = {31'd0, $signed(idEx.rsVal) < $signed(aluB)};
      default: aluRes = idEx.rsVal + aluB;
    endcase
  end

  // EX/MEM next value
  always_comb begin
    exNext          = '0;
    exNext.aluRes   = aluRes;
    exNext.rtVal    = idEx.rtVal;
    exNext.zero     = (aluRes == 32'd0);
    exNext.wr       = idEx.wr;
    exNext.regWrite = idEx.regWrite;
    exNext.memRead  = idEx.memRead;
    exNext.memWrite = idEx.memWrite;
  end

  // MEM: data read and write-back mux
  always_comb begin
    wbNext          = '0;
    wbNext.wbData   = exMem.memRead ? dmem[exMem.aluRes[3:0]]
                                    : exMem.aluRes;
    wbNext.wr       = exMem.wr;
    wbNext.regWrite = exMem.regWrite;
  end

  // PC and pipeline registers advance once per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      ifId  <= '0;
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else if (step) begin
      pc    <= bus.btnSelect ? bus.jmpAddr : pc + 4'd1;
      ifId  <= romData;
      idEx  <= idNext;
      exMem <= exNext;
      memWb <= wbNext;
    end
  end

  // register file: reg[i]=i at reset, writeback from MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
    end else if (step && wbWe) begin
      rf[memWb.wr] <= memWb.wbData;
    end
  end

  // data memory: dmem[i]=16*i at reset, SW commits from EX/MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'(16 * i);
    end else if (step && exMem.memWrite) begin
      dmem[exMem.aluRes[3:0]] <= exMem.rtVal;
    end
  end

  assign bus.zeroAlu  = exMem.zero;
  assign bus.outMuxWb = memWb.wbData;

endmodule

// File: tb/tb_pipeline_core.sv
// Scoreboard bench for pipeline_core: expected write-back values are
// queued per step and compared once the step has been taken.
module tb_pipeline_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] expQ [$];

  pipeline_core_if bus ();

  pipeline_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.btn         = 1'b0;
    bus.btnSelect   = 1'b0;
    bus.btnWRselect = 1'b0;
    bus.btnMuxEx    = 1'b0;
    bus.jmpAddr     = 4'd0;
    repeat (2) @(negedge clk);
    check("rstWb", bus.outMuxWb, 32'd0);
    check("rstZero", {31'd0, bus.zeroAlu}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // one-cycle press, then enough settle time for the synchroniser
  task automatic doStep();
    @(negedge clk);
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic stepExpect(input string tag, input logic [31:0] expWb);
    expQ.push_back(expWb);
    doStep();
    check(tag, bus.outMuxWb, expQ.pop_front());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;

    // reset, then idle
    doReset();
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("idleWb", bus.outMuxWb, 32'd0);
    end
    check("idleZero", {31'd0, bus.zeroAlu}, 32'd0);

    // default program flow
    stepExpect("s1", 32'd0);
    stepExpect("s2", 32'd0);
    stepExpect("s3", 32'd0);
    stepExpect("s4add", 32'd3);
    check("s4zeroSub", {31'd0, bus.zeroAlu}, 32'd1);
    stepExpect("s5sub", 32'd0);
    stepExpect("s6or", 32'd3);
    stepExpect("s7and", 32'd2);
    stepExpect("s8lw", 32'h40);
    check("s8zeroSw", {31'd0, bus.zeroAlu}, 32'd0);
    stepExpect("s9sw", 32'd4);
    check("s9zeroNop", {31'd0, bus.zeroAlu}, 32'd1);
    bus.btnSelect = 1'b1;
    bus.jmpAddr   = 4'd4;
    stepExpect("jmp4", 32'd0);
    bus.btnSelect = 1'b0;
    bus.jmpAddr   = 4'd0;
    stepExpect("j1", 32'd0);
    stepExpect("j2", 32'd0);
    stepExpect("j3", 32'd0);
    stepExpect("lwAfterSw", 32'd1);

    // reset mid-operation with a press pending
    @(negedge clk);
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midRstWb", bus.outMuxWb, 32'd0);
    check("midRstZero", {31'd0, bus.zeroAlu}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("postRstWb", bus.outMuxWb, 32'd0);

    // destination override: ADD writes r2 = 3
    doReset();
    bus.btnWRselect = 1'b1;
    stepExpect("wr1", 32'd0);
    stepExpect("wr2", 32'd0);
    bus.btnWRselect = 1'b0;
    stepExpect("wr3", 32'd0);
    stepExpect("wr4add", 32'd3);
    check("wr4zero", {31'd0, bus.zeroAlu}, 32'd1);
    stepExpect("wr5sub", 32'd0);
    bus.btnSelect = 1'b1;
    bus.jmpAddr   = 4'd0;
    stepExpect("wr6or", 32'd3);
    bus.btnSelect = 1'b0;
    stepExpect("wr7andThru", 32'd3);
    stepExpect("wr8lw", 32'h40);
    stepExpect("wr9sw", 32'd4);
    stepExpect("wr10add", 32'd4);

    // ALU B override during SUB's EX step
    doReset();
    stepExpect("mx1", 32'd0);
    stepExpect("mx2", 32'd0);
    stepExpect("mx3", 32'd0);
    bus.btnMuxEx = 1'b1;
    stepExpect("mx4", 32'd3);
    bus.btnMuxEx = 1'b0;
    check("mx4zero", {31'd0, bus.zeroAlu}, 32'd0);
    stepExpect("mx5subImm", 32'hFFFF_DFE0);

    // overrides without a step change nothing
    @(negedge clk);
    bus.btnWRselect = 1'b1;
    bus.btnMuxEx    = 1'b1;
    #100;
    bus.btnWRselect = 1'b0;
    bus.btnMuxEx    = 1'b0;
    @(negedge clk);
    check("noStepWb", bus.outMuxWb, 32'hFFFF_DFE0);
    check("noStepZero", {31'd0, bus.zeroAlu}, 32'd0);

    // btn held for four clock edges, then three single presses
    doReset();
    @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    repeat (6) @(negedge clk);
    doStep();
    doStep();
    doStep();
`ifdef PIPELINE_BTN_SYNC_EN
    check("holdSteps", bus.outMuxWb, 32'd3);
`else
    check("holdSteps", bus.outMuxWb, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_core.md
# pipeline_core

Button-stepped, five-stage (IF/ID/EX/MEM/WB) 32-bit teaching pipeline with a fixed 16-word instruction ROM, a 32×32 register file, an ALU and a 16-word data memory. External buttons advance the pipeline and override selected datapath muxes, so each stage can be observed on a board. Top-level block of the board design; the module is named `pipeline_core`.

## Interface
- No parameters.
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn`  in  1  step request; one pipeline advance ("step") per request (see Configuration).
- `btnSelect`  in  1  PC source; 1 = `jmpAddr`, 0 = PC+1. Sampled at each step.
- `btnWRselect`  in  1  forces write register = rt (normally rd for R-type).
- `btnMuxEx`  in  1  forces ALU operand B = sign-extended imm16 (normally rt value for R-type).
- `jmpAddr`  in  4  jump target ROM index.
- `zeroAlu`  out  1  zero flag held in the EX/MEM register.
- `outMuxWb`  out  32  write-back mux output from the MEM/WB register.

## Operation
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], sign-extended.
- R-type (op=0) funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed); any other funct = ADD.
- op 0x23 LW and op 0x2B SW use ADD with B=imm. Any other nonzero op is treated as ADD-immediate with no register write.
- ALU B = imm when op≠0 or `btnMuxEx`=1.
- Destination = rt when op≠0 or `btnWRselect`=1, else rd.
- Register write enable: R-type or LW only. Writes to r0 are discarded; r0 always reads 0.
- WB mux: LW selects memory read data; everything else selects the ALU result.
- ROM, fixed: 0 0x00221820 ADD r3,r1,r2; 1 0x00422022 SUB r4,r2,r2; 2 0x00222825 OR r5,r1,r2; 3 0x00E23024 AND r6,r7,r2; 4 0x8C080004 LW r8,4(r0); 5 0xAC010004 SW r1,4(r0); 6–15 0x00000000 (NOP).
- No hazard detection, forwarding or flush.
- The register file is write-through: a same-step write is visible to ID reads.
- Jump: on a step with `btnSelect`=1, PC ← `jmpAddr`. Instructions already fetched still complete.

## Timing
- All state is updated only on `clk` rising edges where a step is active.
- At a step:
  - IF/ID ← ROM[PC]; PC ← `btnSelect` ? `jmpAddr` : PC+1. The 4-bit PC wraps 15→0.
  - ID/EX, EX/MEM and MEM/WB each shift forward.
  - Register writeback from MEM/WB.
  - SW memory write from EX/MEM.
- Instruction fetched at step k is in EX/MEM after step k+2, so `zeroAlu` reflects it.
- It is in MEM/WB after step k+3, so `outMuxWb` shows it.
- Its register write commits at step k+4.
- Reset values:
  - PC=0, and all pipeline registers are 0 (NOP); `outMuxWb`=0 and `zeroAlu`=0.
  - reg[i]=i.
  - dmem[i]=16·i.
  - The step edge detector is cleared.
- Reset asserted mid-operation restores all of the above immediately and ignores a pending step.
- Button inputs other than `btn` are sampled only at steps. Changing them between steps has no effect.

## Configuration
- `PIPELINE_BTN_SYNC_EN` defined:
  - `btn` passes through a 2-flop synchronizer and rising-edge detector.
  - Exactly one step per 0→1 transition, regardless of how long it is held.
- Not defined: `btn` is a level enable, and one step occurs on every `clk` edge while `btn`=1.

## Test plan
- Reset: `rst_n`=0 → `outMuxWb`=0, `zeroAlu`=0. After release with no `btn` activity, outputs stay 0 for 100 cycles.
- Four steps from reset (default buttons) → `outMuxWb`=3 (ADD), `zeroAlu`=1 (SUB in EX/MEM). Steps 5–8 → `outMuxWb`= 0, 3, 2, 0x40.
- Step 9 → `outMuxWb`=4 (SW address). Then jump with `btnSelect`=1, `jmpAddr`=4, plus 4 further steps → `outMuxWb`=1 (LW sees stored r1).
- `btnWRselect`=1 held through the ADD's steps:
  - r2 becomes 3 instead of r3.
  - A later jump to 0 then yields `outMuxWb`=4 (1+3).
- `btnMuxEx`=1 during the SUB's EX step → B=imm 0x2022: result = 2−0x2022, and `zeroAlu`=0.
- Assert `btnWRselect` for 100 ns with `btn`=0 → no state change. Then `btn` held high: with `PIPELINE_BTN_SYNC_EN` exactly one step; without it one step per cycle.
